spu_rf_fwd_stage: RTL and testbench
===================================

# spu_rf_fwd_stage

Register-file/forwarding (RF/FWD) stage of the dual-issue SPU pipeline. It is the receiving end of the even and odd execution pipes' write-back and forwarding buses. It holds the 128 x 128-bit register file and commits both pipes' write-backs into it. For the instruction pair in decode it resolves six source operands (ra/rb/rc per pipe) from in-flight forwarding stages, write-back, or the RF, and registers them toward the execution pipes.

## Interface
Parameters:
- NUM_REGS, 128, register count
- DATA_W, 128, register/operand width
- FW_STAGES, 7, forwarding stages per pipe (index 0 unused, always invalid)

Ports:
- Clock and reset: `reset` is synchronous, active-high; the clock is `clk`.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold operand outputs (decode stalled)
- ev_in_valid, od_in_valid  in  1 each  pair slot carries a real instruction
- ev_ra_addr, ev_rb_addr, ev_rc_addr, od_ra_addr, od_rb_addr, od_rc_addr  in  7 each  source register addresses
- ev_rt_wb, od_rt_wb  in  DATA_W each  write-back value
- ev_rt_addr_wb, od_rt_addr_wb  in  7 each  write-back address
- ev_reg_write_wb, od_reg_write_wb  in  1 each  write-back enable
- ev_fw_wb, od_fw_wb  in  [FW_STAGES][DATA_W]  forwarding stage values
- ev_fw_addr_wb, od_fw_addr_wb  in  [FW_STAGES][7]  forwarding stage addresses
- ev_fw_write_wb, od_fw_write_wb  in  [FW_STAGES]  forwarding stage valid
- ev_ra, ev_rb, ev_rc, od_ra, od_rb, od_rt_st  out  DATA_W each  resolved operands (od_rt_st comes from od_rc_addr)
- ev_out_valid, od_out_valid  out  1 each  registered copy of the in_valid inputs

## Operation
- RF write: on each clk edge with reset=0, ev_reg_write_wb writes ev_rt_wb to RF[ev_rt_addr_wb], and od likewise. If both pipes write the same address, the odd value is stored.
- Operand resolution is combinational from the current cycle's inputs. Priority, highest first:
  - fw stage 1, then 2 … 6 (the youngest producer wins)
  - write-back port
  - RF contents
- Within one stage, a hit on both pipes selects the odd pipe.
- A source hits when its write/valid bit is 1 and its address equals the operand address. Stage index 0 never hits.
- Output registers: when stall=0, all six operand outputs and both out_valid bits load the resolved values. When stall=1, they hold, but RF writes still occur.
- Operands are resolved even when in_valid=0; out_valid then goes to 0.
- Reset: all RF entries, operand outputs and out_valid are set to 0. Reset takes priority over simultaneous writes and over stall.

## Timing
- Addresses are presented in cycle N; operands appear on the outputs after edge N+1 (1-cycle latency).
- Write-back in cycle N is visible to a read in the same cycle N through the write-through path. It is also in the RF from edge N+1 onward.
- Forwarding values sampled in cycle N are the ones used. The block does not track later stage movement.
- Stall release: the first cycle with stall=0 loads operands freshly resolved from that cycle's state. Operands captured during the stall are not used.
- No stall output. RAW hazards that are not covered by forwarding are the execution pipes' responsibility.

## Configuration
- FWD_BYPASS_EN defined: the full priority chain is used (fw stages 1–6, write-back, RF).
- FWD_BYPASS_EN undefined: all fw_* inputs are ignored. Only write-back write-through and the RF are used, and upstream hazard logic must stall until write-back. Port list is unchanged.

## Structure
- Shared package spu_pkg holds:
  - constants DATA_W, REG_ADDR_W=7, FW_STAGES
  - typedef fw_bus_t: value/addr/write arrays for one pipe
- Sub-module spu_fwd_select: one operand's priority mux over both fw buses, both write-back ports and the RF read data. It is instantiated six times. The FWD_BYPASS_EN gating lives inside it.

## Test plan
- Reset, then read r5 on ev_ra with stall=0 → ev_ra = 0 next cycle; all outputs = 0 during reset.
- od WB r3 = 0xAAAA…AAAA in cycle N, then read r3 on ev_rb in cycle N+2 with no fw hits → ev_rb = 0xAAAA…AAAA.
- od WB r7 = 0x1111…1111 and od_ra_addr=7 in the same cycle → od_ra = 0x1111…1111 next cycle (write-through).
- RF r9 = 0; od_fw[4] = {r9, 0x1234, write=1} and ev_fw[2] = {r9, 0x5678, write=1}; read r9 on ev_rc → 0x5678. Same stimulus without FWD_BYPASS_EN → 0.
- ev WB r10 = 0x1 and od WB r10 = 0x2 in the same cycle, then read r10 later → 0x2.
- stall=1 with od_rt_st holding 0xCAFE while WB writes r12 = 0xBEEF and od_rc_addr=12 → od_rt_st stays 0xCAFE. Drop stall → 0xBEEF next cycle.

Source files
------------

// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared constants and forwarding-bus type for the SPU RF/FWD stage
//
// Purpose : register file geometry, operand width and the per-pipe
//           forwarding bus bundle used by spu_rf_fwd_stage / spu_fwd_select.
// Ports   : none (package).
package spu_pkg;

   localparam int NUM_REGS   = 128;
   localparam int DATA_W     = 128;
   localparam int REG_ADDR_W = 7;
   localparam int FW_STAGES  = 7;

   // One pipe's forwarding stages; stage 0 is never a producer.
   typedef struct packed {
      logic [FW_STAGES-1:0][DATA_W-1:0]     value;
      logic [FW_STAGES-1:0][REG_ADDR_W-1:0] addr;
      logic [FW_STAGES-1:0]                 write;
   } fw_bus_t;

endpackage

// File: rtl/spu_rf_fwd_stage_if.sv
// rtl/spu_rf_fwd_stage_if.sv - decode/write-back/forwarding bundle of the RF/FWD stage
//
// Purpose : groups every non-clock/reset signal of spu_rf_fwd_stage.
// Modports: master - decode + execution pipes (drive addresses, WB, fw buses)
//           slave  - spu_rf_fwd_stage (drives resolved operands, out_valid)
interface spu_rf_fwd_stage_if;
   import spu_pkg::*;

   logic                  stall;
   logic                  ev_in_valid;
   logic                  od_in_valid;
   logic [REG_ADDR_W-1:0] ev_ra_addr;
   logic [REG_ADDR_W-1:0] ev_rb_addr;
   logic [REG_ADDR_W-1:0] ev_rc_addr;
   logic [REG_ADDR_W-1:0] od_ra_addr;
   logic [REG_ADDR_W-1:0] od_rb_addr;
   logic [REG_ADDR_W-1:0] od_rc_addr;
   logic [DATA_W-1:0]     ev_rt_wb;
   logic [DATA_W-1:0]     od_rt_wb;
   logic [REG_ADDR_W-1:0] ev_rt_addr_wb;
   logic [REG_ADDR_W-1:0] od_rt_addr_wb;
   logic                  ev_reg_write_wb;
   logic                  od_reg_write_wb;
   logic [DATA_W-1:0]     ev_fw_wb      [FW_STAGES];
   logic [DATA_W-1:0]     od_fw_wb      [FW_STAGES];
   logic [REG_ADDR_W-1:0] ev_fw_addr_wb [FW_STAGES];
   logic [REG_ADDR_W-1:0] od_fw_addr_wb [FW_STAGES];
   logic                  ev_fw_write_wb[FW_STAGES];
   logic                  od_fw_write_wb[FW_STAGES];
   logic [DATA_W-1:0]     ev_ra;
   logic [DATA_W-1:0]     ev_rb;
   logic [DATA_W-1:0]     ev_rc;
   logic [DATA_W-1:0]     od_ra;
   logic [DATA_W-1:0]     od_rb;
   logic [DATA_W-1:0]     od_rt_st;
   logic                  ev_out_valid;
   logic                  od_out_valid;

   modport master (
      output stall, ev_in_valid, od_in_valid,
      output ev_ra_addr, ev_rb_addr, ev_rc_addr, od_ra_addr, od_rb_addr, od_rc_addr,
      output ev_rt_wb, od_rt_wb, ev_rt_addr_wb, od_rt_addr_wb, ev_reg_write_wb, od_reg_write_wb,
      output ev_fw_wb, od_fw_wb, ev_fw_addr_wb, od_fw_addr_wb, ev_fw_write_wb, od_fw_write_wb,
      input  ev_ra, ev_rb, ev_rc, od_ra, od_rb, od_rt_st, ev_out_valid, od_out_valid
   );

   modport slave (
      input  stall, ev_in_valid, od_in_valid,
      input  ev_ra_addr, ev_rb_addr, ev_rc_addr, od_ra_addr, od_rb_addr, od_rc_addr,
      input  ev_rt_wb, od_rt_wb, ev_rt_addr_wb, od_rt_addr_wb, ev_reg_write_wb, od_reg_write_wb,
      input  ev_fw_wb, od_fw_wb, ev_fw_addr_wb, od_fw_addr_wb, ev_fw_write_wb, od_fw_write_wb,
      output ev_ra, ev_rb, ev_rc, od_ra, od_rb, od_rt_st, ev_out_valid, od_out_valid
   );

endinterface

// File: rtl/spu_fwd_select.sv
// rtl/spu_fwd_select.sv - priority mux resolving one source operand
//
// Purpose : picks the youngest producer of i_addr: fw stage 1..6 (odd pipe
//           wins a tie within a stage), then the WB ports (odd wins), then RF.
//           Config macro FWD_BYPASS_EN: when undefined the fw buses are ignored.
// Ports   : i_addr                        operand register address
//           i_ev_fw / i_od_fw             forwarding buses of each pipe
//           i_*_wb_we / _addr / _data     write-back ports of each pipe
//           i_rf_data                     RF read data at i_addr
//           o_data                        resolved operand (combinational)
module spu_fwd_select
   import spu_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] i_addr,
   input  fw_bus_t               i_ev_fw,
   input  fw_bus_t               i_od_fw,
   input  logic                  i_ev_wb_we,
   input  logic [REG_ADDR_W-1:0] i_ev_wb_addr,
   input  logic [DATA_W-1:0]     i_ev_wb_data,
   input  logic                  i_od_wb_we,
   input  logic [REG_ADDR_W-1:0] i_od_wb_addr,
   input  logic [DATA_W-1:0]     i_od_wb_data,
   input  logic [DATA_W-1:0]     i_rf_data,
   output logic [DATA_W-1:0]     o_data
);

   // Stage 0 never forwards, and without bypass nothing on the fw buses is read.
   logic w_unused_fw;
   assign w_unused_fw = ^{i_ev_fw, i_od_fw};

   // Lowest priority assigned first; each later assignment overrides.
   always_comb begin
      o_data = i_rf_data;
      if (i_ev_wb_we && (i_ev_wb_addr == i_addr)) o_data = i_ev_wb_data;
      if (i_od_wb_we && (i_od_wb_addr == i_addr)) o_data = i_od_wb_data;
`ifdef FWD_BYPASS_EN
      for (int s = FW_STAGES - 1; s >= 1; s--) begin
         if (i_ev_fw.write[s] && (i_ev_fw.addr[s] == i_addr)) o_data = i_ev_fw.value[s];
         if (i_od_fw.write[s] && (i_od_fw.addr[s] == i_addr)) o_data = i_od_fw.value[s];
      end
`else
`endif
   end

endmodule

// File: rtl/spu_rf_fwd_stage.sv
// rtl/spu_rf_fwd_stage.sv - SPU register file with write-back commit and operand forwarding
//
// Purpose : 128 x 128-bit RF written by both pipes' WB ports (odd wins on a
//           same-address collision); six operands resolved through
//           spu_fwd_select and registered toward the execution pipes.
//           Config macro FWD_BYPASS_EN enables fw-stage forwarding.
// Ports   : clk    clock
//           reset  synchronous active-high; clears RF, operands, out_valid
//           bus    spu_rf_fwd_stage_if.slave (stall, addresses, WB, fw buses,
//                  resolved operands, out_valid)
module spu_rf_fwd_stage
   import spu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   spu_rf_fwd_stage_if.slave bus
);

   logic [DATA_W-1:0]     r_rf [NUM_REGS];
   logic [DATA_W-1:0]     r_op [6];
   logic                  r_ev_valid;
   logic                  r_od_valid;
   fw_bus_t               w_ev_fw;
   fw_bus_t               w_od_fw;
   logic [REG_ADDR_W-1:0] w_addr [6];
   logic [DATA_W-1:0]     w_res  [6];

   always_comb begin
      w_ev_fw = '0;
      w_od_fw = '0;
      for (int s = 0; s < FW_STAGES; s++) begin
         w_ev_fw.value[s] = bus.ev_fw_wb[s];
         w_ev_fw.addr[s]  = bus.ev_fw_addr_wb[s];
         w_ev_fw.write[s] = bus.ev_fw_write_wb[s];
         w_od_fw.value[s] = bus.od_fw_wb[s];
         w_od_fw.addr[s]  = bus.od_fw_addr_wb[s];
         w_od_fw.write[s] = bus.od_fw_write_wb[s];
      end
   end

   // Operand slot order: ev ra/rb/rc, od ra/rb/rc (od rc feeds od_rt_st).
   assign w_addr[0] = bus.ev_ra_addr;
   assign w_addr[1] = bus.ev_rb_addr;
   assign w_addr[2] = bus.ev_rc_addr;
   assign w_addr[3] = bus.od_ra_addr;
   assign w_addr[4] = bus.od_rb_addr;
   assign w_addr[5] = bus.od_rc_addr;

   for (genvar i = 0; i < 6; i++) begin : g_sel
      spu_fwd_select u_sel (
         .i_addr       (w_addr[i]),
         .i_ev_fw      (w_ev_fw),
         .i_od_fw      (w_od_fw),
         .i_ev_wb_we   (bus.ev_reg_write_wb),
         .i_ev_wb_addr (bus.ev_rt_addr_wb),
         .i_ev_wb_data (bus.ev_rt_wb),
         .i_od_wb_we   (bus.od_reg_write_wb),
         .i_od_wb_addr (bus.od_rt_addr_wb),
         .i_od_wb_data (bus.od_rt_wb),
         .i_rf_data    (r_rf[w_addr[i]]),
         .o_data       (w_res[i])
      );
   end

   // Odd write is issued last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
      end else begin
         if (bus.ev_reg_write_wb) r_rf[bus.ev_rt_addr_wb] <= bus.ev_rt_wb;
         if (bus.od_reg_write_wb) r_rf[bus.od_rt_addr_wb] <= bus.od_rt_wb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 6; i++) r_op[i] <= '0;
         r_ev_valid <= 1'b0;
         r_od_valid <= 1'b0;
      end else if (!bus.stall) begin
         for (int i = 0; i < 6; i++) r_op[i] <= w_res[i];
         r_ev_valid <= bus.ev_in_valid;
         r_od_valid <= bus.od_in_valid;
      end
   end

   assign bus.ev_ra        = r_op[0];
   assign bus.ev_rb        = r_op[1];
   assign bus.ev_rc        = r_op[2];
   assign bus.od_ra        = r_op[3];
   assign bus.od_rb        = r_op[4];
   assign bus.od_rt_st     = r_op[5];
   assign bus.ev_out_valid = r_ev_valid;
   assign bus.od_out_valid = r_od_valid;

endmodule

// File: tb/tb_spu_rf_fwd_stage.sv
// tb/tb_spu_rf_fwd_stage.sv - scoreboard bench for spu_rf_fwd_stage
module tb_spu_rf_fwd_stage;
   import spu_pkg::*;

   typedef struct packed {
      logic [5:0][DATA_W-1:0] op;
      logic                   ev_v;
      logic                   od_v;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   spu_rf_fwd_stage_if u_if ();

   spu_rf_fwd_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   int n_total = 0;
   int n_bad   = 0;
   logic [DATA_W-1:0] model_rf [NUM_REGS];
   exp_t sb[$];
   string nm [6] = '{"ev_ra", "ev_rb", "ev_rc", "od_ra", "od_rb", "od_rt_st"};

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference: walk producers youngest-first and return the first match.
   function automatic logic [DATA_W-1:0] resolve(input logic [REG_ADDR_W-1:0] a);
`ifdef FWD_BYPASS_EN
      for (int s = 1; s < FW_STAGES; s++) begin
         if (u_if.od_fw_write_wb[s] && u_if.od_fw_addr_wb[s] == a) return u_if.od_fw_wb[s];
         if (u_if.ev_fw_write_wb[s] && u_if.ev_fw_addr_wb[s] == a) return u_if.ev_fw_wb[s];
      end
`endif
      if (u_if.od_reg_write_wb && u_if.od_rt_addr_wb == a) return u_if.od_rt_wb;
      if (u_if.ev_reg_write_wb && u_if.ev_rt_addr_wb == a) return u_if.ev_rt_wb;
      return model_rf[a];
   endfunction

   // Called with this cycle's inputs applied, before the edge that samples them.
   task automatic commit();
      exp_t e;
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) model_rf[i] = '0;
         return;
      end
      if (!u_if.stall) begin
         e.op[0] = resolve(u_if.ev_ra_addr);
         e.op[1] = resolve(u_if.ev_rb_addr);
         e.op[2] = resolve(u_if.ev_rc_addr);
         e.op[3] = resolve(u_if.od_ra_addr);
         e.op[4] = resolve(u_if.od_rb_addr);
         e.op[5] = resolve(u_if.od_rc_addr);
         e.ev_v  = u_if.ev_in_valid;
         e.od_v  = u_if.od_in_valid;
         sb.push_back(e);
      end
      if (u_if.ev_reg_write_wb) model_rf[u_if.ev_rt_addr_wb] = u_if.ev_rt_wb;
      if (u_if.od_reg_write_wb) model_rf[u_if.od_rt_addr_wb] = u_if.od_rt_wb;
   endtask

   task automatic step();
      commit();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      u_if.stall = 1'b0;
      u_if.ev_in_valid = 1'b0;  u_if.od_in_valid = 1'b0;
      u_if.ev_ra_addr = '0; u_if.ev_rb_addr = '0; u_if.ev_rc_addr = '0;
      u_if.od_ra_addr = '0; u_if.od_rb_addr = '0; u_if.od_rc_addr = '0;
      u_if.ev_rt_wb = '0; u_if.od_rt_wb = '0;
      u_if.ev_rt_addr_wb = '0; u_if.od_rt_addr_wb = '0;
      u_if.ev_reg_write_wb = 1'b0; u_if.od_reg_write_wb = 1'b0;
      for (int s = 0; s < FW_STAGES; s++) begin
         u_if.ev_fw_wb[s] = '0; u_if.od_fw_wb[s] = '0;
         u_if.ev_fw_addr_wb[s] = '0; u_if.od_fw_addr_wb[s] = '0;
         u_if.ev_fw_write_wb[s] = 1'b0; u_if.od_fw_write_wb[s] = 1'b0;
      end
   endtask

   task automatic randomize_inputs();
      u_if.stall = ($urandom_range(0, 4) == 0);
      u_if.ev_in_valid = $urandom_range(0, 1);
      u_if.od_in_valid = $urandom_range(0, 1);
      u_if.ev_ra_addr = $urandom_range(0, 15); u_if.ev_rb_addr = $urandom_range(0, 15);
      u_if.ev_rc_addr = $urandom_range(0, 15); u_if.od_ra_addr = $urandom_range(0, 15);
      u_if.od_rb_addr = $urandom_range(0, 15); u_if.od_rc_addr = $urandom_range(0, 15);
      u_if.ev_rt_wb = rnd128(); u_if.od_rt_wb = rnd128();
      u_if.ev_rt_addr_wb = $urandom_range(0, 15); u_if.od_rt_addr_wb = $urandom_range(0, 15);
      u_if.ev_reg_write_wb = $urandom_range(0, 1); u_if.od_reg_write_wb = $urandom_range(0, 1);
      for (int s = 0; s < FW_STAGES; s++) begin
         u_if.ev_fw_wb[s] = rnd128(); u_if.od_fw_wb[s] = rnd128();
         u_if.ev_fw_addr_wb[s] = $urandom_range(0, 15); u_if.od_fw_addr_wb[s] = $urandom_range(0, 15);
         u_if.ev_fw_write_wb[s] = ($urandom_range(0, 2) == 0);
         u_if.od_fw_write_wb[s] = ($urandom_range(0, 2) == 0);
      end
   endtask

   // Monitor: a non-stalled, non-reset edge presents a new operand set.
   initial begin
      exp_t last;
      exp_t cur;
      logic [5:0][DATA_W-1:0] act;
      logic s_rst, s_stall;
      last = '0;
      forever begin
         @(posedge clk);
         s_rst = reset;
         s_stall = u_if.stall;
         #1;
         if (s_rst) begin
            cur = '0;
         end else if (!s_stall) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
               cur = last;
            end else begin
               cur = sb.pop_front();
            end
         end else begin
            cur = last;
         end
         act[0] = u_if.ev_ra; act[1] = u_if.ev_rb; act[2] = u_if.ev_rc;
         act[3] = u_if.od_ra; act[4] = u_if.od_rb; act[5] = u_if.od_rt_st;
         for (int k = 0; k < 6; k++) check(nm[k], act[k], cur.op[k]);
         check("ev_out_valid", {127'b0, u_if.ev_out_valid}, {127'b0, cur.ev_v});
         check("od_out_valid", {127'b0, u_if.od_out_valid}, {127'b0, cur.od_v});
         last = cur;
      end
   end

   initial begin
      logic [DATA_W-1:0] pat_a, pat_1;
      pat_a = {32{4'hA}};
      pat_1 = {32{4'h1}};
      idle();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;

      // read r5 right after reset
      idle(); u_if.ev_in_valid = 1'b1; u_if.ev_ra_addr = 7'd5; step();
      check("post_reset_r5", u_if.ev_ra, '0);

      // od WB r3, read two cycles later from the RF
      idle(); u_if.od_reg_write_wb = 1'b1; u_if.od_rt_addr_wb = 7'd3; u_if.od_rt_wb = pat_a; step();
      idle(); step();
      idle(); u_if.ev_rb_addr = 7'd3; step();
      check("rf_read_r3", u_if.ev_rb, pat_a);

      // write-through in the same cycle
      idle(); u_if.od_reg_write_wb = 1'b1; u_if.od_rt_addr_wb = 7'd7; u_if.od_rt_wb = pat_1;
      u_if.od_ra_addr = 7'd7; step();
      check("write_through_r7", u_if.od_ra, pat_1);

      // forwarding priority: ev stage 2 beats od stage 4
      idle(); u_if.ev_reg_write_wb = 1'b1; u_if.ev_rt_addr_wb = 7'd9; step();
      idle();
      u_if.od_fw_addr_wb[4] = 7'd9; u_if.od_fw_wb[4] = 128'h1234; u_if.od_fw_write_wb[4] = 1'b1;
      u_if.ev_fw_addr_wb[2] = 7'd9; u_if.ev_fw_wb[2] = 128'h5678; u_if.ev_fw_write_wb[2] = 1'b1;
      u_if.ev_rc_addr = 7'd9; step();
`ifdef FWD_BYPASS_EN
      check("fw_prio_r9", u_if.ev_rc, 128'h5678);
`else
      check("fw_ignored_r9", u_if.ev_rc, '0);
`endif

      // both pipes write r10: odd value stored
      idle(); u_if.ev_reg_write_wb = 1'b1; u_if.ev_rt_addr_wb = 7'd10; u_if.ev_rt_wb = 128'h1;
      u_if.od_reg_write_wb = 1'b1; u_if.od_rt_addr_wb = 7'd10; u_if.od_rt_wb = 128'h2; step();
      idle(); u_if.ev_ra_addr = 7'd10; step();
      check("wb_collision_r10", u_if.ev_ra, 128'h2);

      // stall holds od_rt_st while RF still updates
      idle(); u_if.od_reg_write_wb = 1'b1; u_if.od_rt_addr_wb = 7'd12; u_if.od_rt_wb = 128'hCAFE; step();
      idle(); u_if.od_rc_addr = 7'd12; step();
      check("pre_stall_r12", u_if.od_rt_st, 128'hCAFE);
      idle(); u_if.stall = 1'b1; u_if.od_rc_addr = 7'd12;
      u_if.od_reg_write_wb = 1'b1; u_if.od_rt_addr_wb = 7'd12; u_if.od_rt_wb = 128'hBEEF; step();
      check("stall_hold_r12", u_if.od_rt_st, 128'hCAFE);
      idle(); u_if.od_rc_addr = 7'd12; step();
      check("stall_release_r12", u_if.od_rt_st, 128'hBEEF);

      // reset beats stall and simultaneous writes
      idle(); u_if.stall = 1'b1; u_if.od_reg_write_wb = 1'b1; u_if.od_rt_addr_wb = 7'd12;
      reset = 1'b1; step();
      reset = 1'b0;
      idle(); u_if.od_rc_addr = 7'd12; step();
      check("reset_clears_r12", u_if.od_rt_st, '0);

      // randomized traffic over a small register window
      for (int c = 0; c < 600; c++) begin
         randomize_inputs();
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;
      idle();
      repeat (3) step();
      check("sb_drained", 128'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
